// File: rtl/fifo_to_vip_stream.sv
// Drains a FWFT grayscale pixel FIFO into an Avalon-ST Video stream: one control packet,
// then one video packet per frame, with each pixel replicated to three colour symbols.
module fifo_to_vip_stream #(
   parameter int         WIDTH            = 1280,
   parameter int         HEIGHT           = 720,
   parameter logic [3:0] INTERLACE_NIBBLE = 4'h0
) (
   input  logic        clock,
   input  logic        reset,
   output logic        in_rd_en,
   input  logic        in_empty,
   input  logic [7:0]  in_dout,
   output logic [23:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sop,
   output logic        out_eop,
   output logic        frame_done
);

   localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [15:0]      W_VEC    = 16'(WIDTH);
   localparam logic [15:0]      H_VEC    = 16'(HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

   typedef enum logic [2:0] {
      IDLE,
      CTRL_HDR,
      CTRL_D0,
      CTRL_D1,
      CTRL_D2,
      VID_HDR,
      VID_DATA
   } state_t;

   state_t           state_reg, state_next;
   logic [COL_W-1:0] col_reg, col_next;
   logic [ROW_W-1:0] row_reg, row_next;
   logic             frame_done_reg, frame_done_next;
   logic [23:0]      pixel_rep;
   logic             last_pix;
   logic             pix_accept;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sym
         assign pixel_rep[gi*8 +: 8] = in_dout;
      end
   endgenerate

   assign last_pix   = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
   // Pixel beat handshake built from inputs only, so the FIFO pop stays loop-free.
   assign pix_accept = !in_empty && out_ready;
   assign frame_done = frame_done_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         col_reg        <= '0;
         row_reg        <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         col_reg        <= col_next;
         row_reg        <= row_next;
         frame_done_reg <= frame_done_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      col_next        = col_reg;
      row_next        = row_reg;
      frame_done_next = 1'b0;
      out_valid       = 1'b0;
      out_sop         = 1'b0;
      out_eop         = 1'b0;
      out_data        = '0;
      in_rd_en        = 1'b0;
      case (state_reg)
         IDLE: state_next = CTRL_HDR;
         CTRL_HDR: begin
            out_valid = 1'b1;
            out_sop   = 1'b1;
            out_data  = 24'h00000F;
            if (out_ready) state_next = CTRL_D0;
         end
         CTRL_D0: begin
            out_valid = 1'b1;
            out_data  = {4'h0, W_VEC[7:4], 4'h0, W_VEC[11:8], 4'h0, W_VEC[15:12]};
            if (out_ready) state_next = CTRL_D1;
         end
         CTRL_D1: begin
            out_valid = 1'b1;
            out_data  = {4'h0, H_VEC[11:8], 4'h0, H_VEC[15:12], 4'h0, W_VEC[3:0]};
            if (out_ready) state_next = CTRL_D2;
         end
         CTRL_D2: begin
            out_valid = 1'b1;
            out_eop   = 1'b1;
            out_data  = {4'h0, INTERLACE_NIBBLE, 4'h0, H_VEC[3:0], 4'h0, H_VEC[7:4]};
            if (out_ready) state_next = VID_HDR;
         end
         VID_HDR: begin
            out_valid = 1'b1;
            out_sop   = 1'b1;
            if (out_ready) state_next = VID_DATA;
         end
         VID_DATA: begin
            out_valid = !in_empty;
            out_data  = pixel_rep;
            out_eop   = last_pix;
            in_rd_en  = pix_accept;
            if (pix_accept) begin
               if (last_pix) begin
                  col_next        = '0;
                  row_next        = '0;
                  frame_done_next = 1'b1;
                  state_next      = CTRL_HDR;
               end else if (col_reg == COL_LAST) begin
                  col_next = '0;
                  row_next = row_reg + ROW_W'(1);
               end else begin
                  col_next = col_reg + COL_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fifo_to_vip_stream.sv
// Bench for fifo_to_vip_stream: a FIFO model and beat scoreboard drive a small 4x2 instance,
// and a default-parameter instance is checked against a table of control-packet vectors.
module tb_fifo_to_vip_stream;

   typedef struct {
      logic [23:0] data;
      logic        sop;
      logic        eop;
      logic        pix;
   } beat_t;

   typedef struct {
      logic        ready;
      logic        valid;
      logic [23:0] data;
      logic        sop;
      logic        eop;
   } vec_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset = 1'b1;

   logic        s_rd_en, s_empty, s_ready, s_valid, s_sop, s_eop, s_fd;
   logic [7:0]  s_dout;
   logic [23:0] s_data;
   logic        b_rd_en, b_ready, b_valid, b_sop, b_eop, b_fd;
   logic [23:0] b_data;

   fifo_to_vip_stream #(.WIDTH(4), .HEIGHT(2), .INTERLACE_NIBBLE(4'h3)) dut_small (
      .clock(clock), .reset(reset), .in_rd_en(s_rd_en), .in_empty(s_empty), .in_dout(s_dout),
      .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready), .out_sop(s_sop),
      .out_eop(s_eop), .frame_done(s_fd));

   fifo_to_vip_stream dut_big (
      .clock(clock), .reset(reset), .in_rd_en(b_rd_en), .in_empty(1'b1), .in_dout(8'h00),
      .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready), .out_sop(b_sop),
      .out_eop(b_eop), .frame_done(b_fd));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Small-instance model state.
   logic [7:0]  fifo_q[$];
   beat_t       exp_q[$];
   beat_t       hdr_tab[5];
   logic        toggle_mode = 1'b0;
   logic        expect_stall = 1'b0;
   logic        hold_valid = 1'b0;
   logic [25:0] held_vec = '0;
   logic        fd_exp = 1'b0, fd_exp_next = 1'b0;
   logic        pop_pending = 1'b0;
   int          pops = 0, frames = 0, fd_pulses = 0;
   bit          big_done = 1'b0;

   task automatic drive_fifo();
      s_empty = (fifo_q.size() == 0);
      s_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'hEE;
   endtask

   task automatic push_hdr();
      for (int i = 0; i < 5; i++) exp_q.push_back(hdr_tab[i]);
   endtask

   task automatic push_pixels(input logic [7:0] base, input int first, input int n);
      beat_t b;
      for (int i = first; i < first + n; i++) begin
         fifo_q.push_back(base + 8'(i));
         b.data = {3{base + 8'(i)}};
         b.sop  = 1'b0;
         b.eop  = (i == 7);
         b.pix  = 1'b1;
         exp_q.push_back(b);
      end
      drive_fifo();
   endtask

   // One frame of pixels followed by the next frame's control + video headers.
   task automatic push_frame(input logic [7:0] base);
      push_pixels(base, 0, 8);
      push_hdr();
   endtask

   // Called at posedge+1; samples at the negedge, then applies FIFO pops after the next posedge.
   task automatic step();
      beat_t e;
      logic  acc;
      @(negedge clock);
      if (hold_valid) begin
         chk("stable_valid", {31'd0, s_valid}, 32'd1);
         chk("stable_beat", {6'd0, s_sop, s_eop, s_data}, {6'd0, held_vec});
      end
      if (expect_stall) begin
         chk("stall_valid", {31'd0, s_valid}, 32'd0);
         chk("stall_rd_en", {31'd0, s_rd_en}, 32'd0);
      end
      chk("frame_done", {31'd0, s_fd}, {31'd0, fd_exp});
      if (s_fd) fd_pulses++;
      acc = s_valid && s_ready;
      fd_exp_next = 1'b0;
      if (acc) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got data %h sop %b eop %b, none expected", s_data, s_sop, s_eop);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", {8'd0, s_data}, {8'd0, e.data});
            chk("beat_sop_eop", {30'd0, s_sop, s_eop}, {30'd0, e.sop, e.eop});
            chk("rd_en_on_accept", {31'd0, s_rd_en}, {31'd0, e.pix});
            if (e.pix && e.eop) begin
               frames++;
               fd_exp_next = 1'b1;
            end
         end
      end else begin
         chk("rd_en_no_accept", {31'd0, s_rd_en}, 32'd0);
      end
      hold_valid  = s_valid && !s_ready;
      held_vec    = {s_sop, s_eop, s_data};
      pop_pending = s_rd_en && !s_empty;
      @(posedge clock);
      #1;
      fd_exp = fd_exp_next;
      if (pop_pending) begin
         void'(fifo_q.pop_front());
         pops++;
      end
      s_ready = toggle_mode ? ~s_ready : 1'b1;
      drive_fifo();
   endtask

   task automatic run_frames(input int n, input int budget, output int used);
      int target;
      target = frames + n;
      used = 0;
      while (frames < target && used < budget) begin
         step();
         used++;
      end
      if (frames < target) begin
         n_cmp++;
         n_bad++;
         $display("FAIL frame_timeout: got %0d frames, required %0d", frames, target);
      end
   endtask

   task automatic run_pops(input int target, input int budget);
      int used;
      used = 0;
      while (pops < target && used < budget) begin
         step();
         used++;
      end
      if (pops < target) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pop_timeout: got %0d pops, required %0d", pops, target);
      end
   endtask

   // Default-parameter instance: control packet and video header, with one stalled cycle.
   initial begin : big_check
      vec_t big_tab[7];
      big_tab[0] = '{1'b1, 1'b1, 24'h00000F, 1'b1, 1'b0};
      big_tab[1] = '{1'b0, 1'b1, 24'h000500, 1'b0, 1'b0};
      big_tab[2] = '{1'b1, 1'b1, 24'h000500, 1'b0, 1'b0};
      big_tab[3] = '{1'b1, 1'b1, 24'h020000, 1'b0, 1'b0};
      big_tab[4] = '{1'b1, 1'b1, 24'h00000D, 1'b0, 1'b1};
      big_tab[5] = '{1'b1, 1'b1, 24'h000000, 1'b1, 1'b0};
      big_tab[6] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};
      b_ready = 1'b1;
      @(negedge clock);
      chk("big_reset_out", {4'd0, b_valid, b_sop, b_eop, b_rd_en, b_data}, 32'd0);
      chk("big_reset_fd", {31'd0, b_fd}, 32'd0);
      @(negedge reset);
      @(negedge clock);
      chk("big_idle_valid", {31'd0, b_valid}, 32'd0);
      for (int i = 0; i < 7; i++) begin
         @(posedge clock);
         #1;
         b_ready = big_tab[i].ready;
         @(negedge clock);
         $display("big vec %0d: ready %b valid %b data %h sop %b eop %b", i, b_ready, b_valid, b_data, b_sop, b_eop);
         chk("big_valid", {31'd0, b_valid}, {31'd0, big_tab[i].valid});
         chk("big_data", {8'd0, b_data}, {8'd0, big_tab[i].data});
         chk("big_sop_eop", {30'd0, b_sop, b_eop}, {30'd0, big_tab[i].sop, big_tab[i].eop});
         chk("big_rd_en", {31'd0, b_rd_en}, 32'd0);
      end
      big_done = 1'b1;
   end

   initial begin : main
      int used;
      int pops_before;
      hdr_tab[0] = '{24'h00000F, 1'b1, 1'b0, 1'b0};
      hdr_tab[1] = '{24'h000000, 1'b0, 1'b0, 1'b0};
      hdr_tab[2] = '{24'h000004, 1'b0, 1'b0, 1'b0};
      hdr_tab[3] = '{24'h030200, 1'b0, 1'b1, 1'b0};
      hdr_tab[4] = '{24'h000000, 1'b1, 1'b0, 1'b0};
      s_ready = 1'b1;
      drive_fifo();
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_out", {4'd0, s_valid, s_sop, s_eop, s_rd_en, s_data}, 32'd0);
      chk("reset_fd", {31'd0, s_fd}, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("idle_valid", {31'd0, s_valid}, 32'd0);
      @(posedge clock);
      #1;
      push_hdr();

      // Preloaded frame, sink always ready.
      pops_before = pops;
      push_frame(8'h10);
      run_frames(1, 60, used);
      $display("frame ready=1: %0d pops", pops - pops_before);
      chk("pops_frame1", pops - pops_before, 32'd8);

      // Sink ready toggling every cycle.
      toggle_mode = 1'b1;
      pops_before = pops;
      push_frame(8'h20);
      run_frames(1, 120, used);
      toggle_mode = 1'b0;
      $display("frame ready toggling: %0d pops", pops - pops_before);
      chk("pops_toggle", pops - pops_before, 32'd8);

      // FIFO runs dry after the last pixel of row 0.
      pops_before = pops;
      push_pixels(8'h30, 0, 4);
      run_pops(pops_before + 4, 60);
      expect_stall = 1'b1;
      repeat (10) step();
      expect_stall = 1'b0;
      push_pixels(8'h30, 4, 4);
      push_hdr();
      run_frames(1, 60, used);
      $display("frame with empty stall: %0d pops", pops - pops_before);
      chk("pops_stall", pops - pops_before, 32'd8);

      // Back-to-back frames at full rate: 5 + 8 + 5 + 8 beats, no bubbles.
      push_frame(8'h40);
      push_frame(8'h50);
      run_frames(2, 100, used);
      $display("back-to-back frames: %0d cycles", used);
      chk("b2b_cycles", used, 32'd26);

      // Reset asserted mid-frame after pixel 5 has been popped.
      pops_before = pops;
      push_frame(8'h60);
      run_pops(pops_before + 6, 60);
      #2;
      reset = 1'b1;
      #1;
      $display("mid-frame reset: valid %b data %h rd_en %b", s_valid, s_data, s_rd_en);
      chk("midrst_out", {4'd0, s_valid, s_sop, s_eop, s_rd_en, s_data}, 32'd0);
      chk("midrst_fd", {31'd0, s_fd}, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_q.delete();
      fifo_q.delete();
      hold_valid  = 1'b0;
      fd_exp      = 1'b0;
      pop_pending = 1'b0;
      s_ready     = 1'b1;
      drive_fifo();
      @(negedge clock);
      chk("midrst_idle_valid", {31'd0, s_valid}, 32'd0);
      chk("midrst_idle_rd_en", {31'd0, s_rd_en}, 32'd0);
      @(posedge clock);
      #1;
      push_hdr();
      push_frame(8'h70);
      run_frames(1, 60, used);
      $display("frame after reset: done");

      repeat (6) step();
      chk("exp_q_drained", exp_q.size(), 32'd0);
      chk("frames_total", frames, 32'd6);
      chk("fd_pulses", fd_pulses, 32'd6);
      if (!big_done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL big_check_incomplete: got done=0 required done=1");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
